// File: rtl/cfg_bus_master.sv
// Initiator for the clock-divider configuration bus: buffers upstream writes in a
// small FIFO and issues them one at a time with accept/timeout handling.
module cfg_bus_master #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255,
    parameter int GAP_CYCLES = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    input  logic [3:0]                    req_addr,
    input  logic [7:0]                    req_data,
    output logic                          req_ready,
    output logic                          c_valid,
    output logic [3:0]                    c_addr,
    output logic [7:0]                    c_data,
    input  logic                          c_ready,
    output logic                          busy,
    output logic                          done,
    output logic                          err_timeout,
    input  logic                          err_clr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

    logic [11:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] count_q, count_d;
    logic [1:0]    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          c_valid_q, c_valid_d;
    logic [3:0]    c_addr_q, c_addr_d;
    logic [7:0]    c_data_q, c_data_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic full, empty, push, pop, set_err;
    logic [11:0] head;

    always_comb begin
        full  = (count_q == FULL_LVL);
        empty = (count_q == '0);
        push  = req_valid && !full;
        pop   = (state_q == S_IDLE) && !empty;
        head  = mem_q[rd_ptr_q];
    end

    // Control FSM: IDLE pops the head, ISSUE holds the bus, GAP enforces spacing.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        gap_d     = gap_q;
        c_valid_d = c_valid_q;
        c_addr_d  = c_addr_q;
        c_data_d  = c_data_q;
        done_d    = 1'b0;
        set_err   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    c_addr_d  = head[11:8];
                    c_data_d  = head[7:0];
                    c_valid_d = 1'b1;
                    timer_d   = '0;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Acceptance is checked before the timeout so a late c_ready still completes.
                if (c_ready) begin
                    done_d    = 1'b1;
                    c_valid_d = 1'b0;
                    gap_d     = '0;
                    state_d   = S_GAP;
                end else if (timer_q == TMO_LAST) begin
                    set_err   = 1'b1;
                    c_valid_d = 1'b0;
                    gap_d     = '0;
                    state_d   = S_GAP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                c_valid_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // A timeout set outranks a clear arriving on the same edge.
        if (set_err) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // Storage array is not reset; pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {req_addr, req_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            timer_q   <= '0;
            gap_q     <= '0;
            c_valid_q <= 1'b0;
            c_addr_q  <= '0;
            c_data_q  <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            timer_q   <= timer_d;
            gap_q     <= gap_d;
            c_valid_q <= c_valid_d;
            c_addr_q  <= c_addr_d;
            c_data_q  <= c_data_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign req_ready   = !full;
    assign c_valid     = c_valid_q;
    assign c_addr      = c_addr_q;
    assign c_data      = c_data_q;
    assign done        = done_q;
    assign err_timeout = err_q;
    assign fifo_level  = count_q;
    assign busy        = (state_q != S_IDLE) || !empty;

endmodule

// File: tb/tb_cfg_bus_master.sv
// Directed bench for cfg_bus_master (FIFO_DEPTH=4, TIMEOUT=8, GAP_CYCLES=1).
module tb_cfg_bus_master;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic [3:0] req_addr;
    logic [7:0] req_data;
    logic       req_ready;
    logic       c_valid;
    logic [3:0] c_addr;
    logic [7:0] c_data;
    logic       c_ready;
    logic       busy;
    logic       done;
    logic       err_timeout;
    logic       err_clr;
    logic [2:0] fifo_level;

    int checks = 0;
    int errors = 0;

    cfg_bus_master #(.FIFO_DEPTH(4), .TIMEOUT(8), .GAP_CYCLES(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
        .c_valid(c_valid), .c_addr(c_addr), .c_data(c_data), .c_ready(c_ready),
        .busy(busy), .done(done), .err_timeout(err_timeout), .err_clr(err_clr),
        .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [3:0] a2 [5] = '{4'h4, 4'h4, 4'h8, 4'h4, 4'h8};
    logic [7:0] d2 [5] = '{8'h04, 8'h02, 8'h02, 8'h00, 8'h00};
    logic [3:0] a3 [6] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'hF, 4'h6};
    logic [7:0] d3 [6] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hFF, 8'hA6};

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_data = '0;
        c_ready = 1'b0; err_clr = 1'b0;
        tick(); tick();
        chk("rst_c_valid", c_valid, 0);
        chk("rst_c_addr", c_addr, 0);
        chk("rst_c_data", c_data, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err_timeout, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 1);
        rst = 1'b0;

        // Single write with c_ready tied high
        c_ready = 1'b1;
        tick();
        chk("idle_ready_ignored", done, 0);
        req_valid = 1'b1; req_addr = 4'b0100; req_data = 8'h04;
        tick();
        req_valid = 1'b0;
        chk("t1_level", fifo_level, 1);
        chk("t1_cv_lat1", c_valid, 0);
        chk("t1_busy", busy, 1);
        tick();
        chk("t1_cv", c_valid, 1);
        chk("t1_addr", c_addr, 4'h4);
        chk("t1_data", c_data, 8'h04);
        chk("t1_level0", fifo_level, 0);
        tick();
        chk("t1_done", done, 1);
        chk("t1_cv_drop", c_valid, 0);
        chk("t1_busy_gap", busy, 1);
        tick();
        chk("t1_done_once", done, 0);
        chk("t1_busy_end", busy, 0);
        chk("t1_addr_hold", c_addr, 4'h4);

        // Back-to-back sequence, c_ready three cycles after each rise
        c_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1; req_addr = a2[i]; req_data = d2[i];
            tick();
            if (i == 1) begin
                chk("t2_first_cv", c_valid, 1);
                chk("t2_first_addr", c_addr, a2[0]);
            end
        end
        req_valid = 1'b0;
        chk("t2_level_full", fifo_level, 4);
        chk("t2_req_ready_full", req_ready, 0);
        chk("t2_hold_addr0", c_addr, a2[0]);
        chk("t2_hold_data0", c_data, d2[0]);
        c_ready = 1'b1;
        tick();
        chk("t2_done0", done, 1);
        chk("t2_cv_low0", c_valid, 0);
        c_ready = 1'b0;
        for (int k = 1; k < 5; k++) begin
            tick();
            chk("t2_gap_low", c_valid, 0);
            chk("t2_gap_nodone", done, 0);
            tick();
            chk("t2_cv_rise", c_valid, 1);
            chk("t2_addr", c_addr, a2[k]);
            chk("t2_data", c_data, d2[k]);
            for (int j = 0; j < 3; j++) begin
                tick();
                chk("t2_hold_cv", c_valid, 1);
                chk("t2_hold_addr", c_addr, a2[k]);
                chk("t2_hold_data", c_data, d2[k]);
            end
            c_ready = 1'b1;
            tick();
            chk("t2_done", done, 1);
            chk("t2_cv_low", c_valid, 0);
            c_ready = 1'b0;
        end
        tick();
        chk("t2_busy_end", busy, 0);

        // FIFO full with c_ready low, first entry times out
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1; req_addr = a3[i]; req_data = d3[i];
            tick();
        end
        chk("t3_level4", fifo_level, 4);
        chk("t3_req_ready0", req_ready, 0);
        chk("t3_cv", c_valid, 1);
        chk("t3_addr0", c_addr, a3[0]);
        req_addr = a3[5]; req_data = d3[5];
        for (int j = 0; j < 4; j++) begin
            tick();
            chk("t3_cv_held", c_valid, 1);
            chk("t3_level_held", fifo_level, 4);
            chk("t3_sixth_blocked", req_ready, 0);
        end
        tick();
        chk("t3_tmo_cv", c_valid, 0);
        chk("t3_tmo_err", err_timeout, 1);
        chk("t3_tmo_nodone", done, 0);
        chk("t3_tmo_level", fifo_level, 4);
        tick();
        chk("t3_gap_cv", c_valid, 0);
        chk("t3_gap_ready", req_ready, 0);
        tick();
        chk("t3_next_cv", c_valid, 1);
        chk("t3_next_addr", c_addr, a3[1]);
        chk("t3_next_data", c_data, d3[1]);
        chk("t3_pop_level", fifo_level, 3);
        chk("t3_pop_ready", req_ready, 1);
        tick();
        req_valid = 1'b0;
        chk("t3_sixth_in", fifo_level, 4);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t3_err_clr", err_timeout, 0);

        // Race: c_ready arrives on the cycle the timeout would fire
        for (int j = 0; j < 5; j++) begin
            tick();
            chk("t4_cv_held", c_valid, 1);
            chk("t4_addr", c_addr, a3[1]);
        end
        c_ready = 1'b1;
        tick();
        c_ready = 1'b0;
        chk("t4_race_done", done, 1);
        chk("t4_race_err", err_timeout, 0);
        chk("t4_race_cv", c_valid, 0);

        // Reset during ISSUE with three entries queued
        tick(); tick();
        chk("t5_cv", c_valid, 1);
        chk("t5_addr", c_addr, a3[2]);
        chk("t5_level3", fifo_level, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_cv_drop", c_valid, 0);
        chk("t5_level0", fifo_level, 0);
        chk("t5_busy0", busy, 0);
        chk("t5_addr0", c_addr, 0);
        chk("t5_req_ready", req_ready, 1);
        for (int j = 0; j < 4; j++) begin
            tick();
            chk("t5_quiet_cv", c_valid, 0);
            chk("t5_quiet_busy", busy, 0);
            chk("t5_quiet_done", done, 0);
        end

        // Timeout set outranks err_clr on the same edge
        req_valid = 1'b1; req_addr = 4'h0; req_data = 8'h5A;
        tick();
        req_valid = 1'b0;
        tick();
        chk("t6_cv", c_valid, 1);
        chk("t6_data", c_data, 8'h5A);
        for (int j = 0; j < 7; j++) begin
            tick();
            chk("t6_cv_held", c_valid, 1);
        end
        err_clr = 1'b1;
        tick();
        chk("t6_set_wins", err_timeout, 1);
        chk("t6_cv_low", c_valid, 0);
        chk("t6_nodone", done, 0);
        tick();
        err_clr = 1'b0;
        chk("t6_cleared", err_timeout, 0);
        tick();
        chk("t6_busy_end", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
